// File: rtl/arb_mux.sv
// N-channel arbitrating mux (fixed priority or round robin) with one registered output beat.
// One-cycle latency; in_ready drops for every channel while the output beat is stalled.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_sel
);

    logic [SELW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SELW-1:0]  r_sel;

    logic [SELW-1:0]  w_base;
    logic [N-1:0]     w_rot;
    logic [SELW:0]    w_sum;
    logic [SELW-1:0]  w_gnt;
    logic             w_found;
    logic             w_load_en;
    logic             w_xfer;
    logic [WIDTH-1:0] w_ch [N];

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign w_load_en = !r_valid || out_ready;
    assign w_base    = (MODE == 1) ? r_ptr : '0;

    // Rotate so bit 0 is the channel at the pointer; first set bit is the winner.
    assign w_rot = N'({in_valid, in_valid} >> w_base);

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, w_base} + (SELW+1)'(k);
            end
        end
        if (w_sum >= (SELW+1)'(N)) begin
            w_sum = w_sum - (SELW+1)'(N);
        end
        w_gnt = w_sum[SELW-1:0];
    end

    always_comb begin
        in_ready = '0;
        if (w_found && w_load_en && !reset) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    assign w_xfer = |in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (MODE == 1 && w_xfer) begin
            r_ptr <= (w_gnt == SELW'(N-1)) ? '0 : w_gnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_ch[w_gnt];
            r_sel   <= w_gnt;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sel   = r_sel;

endmodule
